sensor_frame_capture: RTL and testbench

// Downstream of the sensor timing generator. Samples the sensor ADC word on every acq_timing

---
 rtl/sensor_pkg.sv | 26 ++
 rtl/sensor_frame_capture_if.sv | 31 +++
 rtl/sensor_frame_ram.sv | 40 ++++
 rtl/sensor_frame_capture.sv | 158 +++++++++++++++
 tb/tb_sensor_frame_capture.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sensor_pkg.sv
// Shared constants and types for the sensor frame capture block.
//   DATA_W     ADC sample width
//   CHANNELS   channels per sensor cycle / frame
//   CH_W       channel index width
//   FRAME_ID_W published frame id width
//   CNT_W      overrun counter width
package sensor_pkg;

  localparam int DATA_W     = 12;
  localparam int CHANNELS   = 256;
  localparam int CH_W       = 8;
  localparam int FRAME_ID_W = 16;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_COMMIT  = 2'd2
  } cap_state_t;

  // One extra bit so the counter can sit at CHANNELS after the last write.
  typedef logic [CH_W:0] ch_cnt_t;

  localparam ch_cnt_t LAST_CH = ch_cnt_t'(CHANNELS - 1);

endpackage

// File: rtl/sensor_frame_capture_if.sv
// Reader-side bus of the frame capture block.
//   rd_addr      reader channel address into the published frame
//   rd_data      sample at rd_addr, one cycle after rd_addr
//   frame_ready  a published frame is waiting for the reader
//   frame_ack    one-cycle pulse from the reader releasing the frame
//   frame_id     id of the published frame
//   peak_val     largest sample of the published frame
//   peak_ch      channel of peak_val (lowest channel on a tie)
// master = capture block, slave = frame reader.
interface sensor_frame_capture_if;
  import sensor_pkg::*;

  logic [CH_W-1:0]       rd_addr;
  logic [DATA_W-1:0]     rd_data;
  logic                  frame_ready;
  logic                  frame_ack;
  logic [FRAME_ID_W-1:0] frame_id;
  logic [DATA_W-1:0]     peak_val;
  logic [CH_W-1:0]       peak_ch;

  modport master (
    input  rd_addr, frame_ack,
    output rd_data, frame_ready, frame_id, peak_val, peak_ch
  );

  modport slave (
    output rd_addr, frame_ack,
    input  rd_data, frame_ready, frame_id, peak_val, peak_ch
  );

endinterface

// File: rtl/sensor_frame_ram.sv
// Ping-pong frame store: simple dual-port RAM, one write port and one
// registered read port. The MSB of each address selects the bank.
//   clk_4M   clock
//   sys_rst  async active-low reset, clears only the read register
//   wr_en    write strobe
//   wr_addr  {bank, channel} write address
//   wr_data  sample to store
//   rd_addr  {bank, channel} read address
//   rd_data  registered read data
module sensor_frame_ram #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 9
) (
  input  logic              clk_4M,
  input  logic              sys_rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Array left without reset so it maps onto a RAM macro.
  always_ff @(posedge clk_4M) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk_4M or negedge sys_rst) begin
    if (!sys_rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sensor_frame_capture.sv
// Captures one ADC word per acq_timing strobe into a ping-pong frame buffer,
// tracks the frame peak and hands complete frames to a reader by ready/ack.
//   clk_4M       sensor clock
//   sys_rst      async active-low reset
//   sen_rst      sensor reset pulse; its falling edge starts a cycle
//   acq_timing   one-cycle sample strobe
//   adc_data     ADC word, valid with acq_timing
//   short_err    sticky: a cycle restarted before all channels arrived
//   overrun_cnt  frames dropped because the reader still held its bank
//   rd_bus       reader bus (see sensor_frame_capture_if)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a sen_rst fall, strobes ignored
// ST_CAPTURE | storing strobed samples into the write bank
// ST_COMMIT  | one cycle: publish the frame or drop it as an overrun
module sensor_frame_capture
  import sensor_pkg::*;
(
  input  logic                   clk_4M,
  input  logic                   sys_rst,
  input  logic                   sen_rst,
  input  logic                   acq_timing,
  input  logic [DATA_W-1:0]      adc_data,
  output logic                   short_err,
  output logic [CNT_W-1:0]       overrun_cnt,
  sensor_frame_capture_if.master rd_bus
);

  cap_state_t        state, state_nxt;
  logic              sen_rst_d;
  logic              fall;
  logic              wr_en;
  logic              cnt_clr;
  logic              short_set;
  logic              commit_go;
  logic              publish;
  ch_cnt_t           ch_cnt;
  ch_cnt_t           ch_base;
  logic [CH_W-1:0]   wr_ch;
  logic              wr_bank;
  logic [DATA_W-1:0] run_peak_val, peak_base_val;
  logic [CH_W-1:0]   run_peak_ch, peak_base_ch;

  always_ff @(posedge clk_4M or negedge sys_rst) begin
    if (!sys_rst) begin
      sen_rst_d <= 1'b1;
    end else begin
      sen_rst_d <= sen_rst;
    end
  end

  assign fall = sen_rst_d & ~sen_rst;

  always_ff @(posedge clk_4M or negedge sys_rst) begin
    if (!sys_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A fall always restarts the cycle; a strobe in the same cycle becomes
  // channel 0 of the new cycle.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    cnt_clr   = 1'b0;
    short_set = 1'b0;
    commit_go = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fall) begin
          cnt_clr   = 1'b1;
          wr_en     = acq_timing;
          state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        cnt_clr   = fall;
        wr_en     = acq_timing;
        short_set = fall && (ch_cnt < ch_cnt_t'(CHANNELS));
        if (acq_timing && !fall && ch_cnt == LAST_CH) begin
          state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        commit_go = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign ch_base       = cnt_clr ? '0 : ch_cnt;
  assign wr_ch         = ch_base[CH_W-1:0];
  assign peak_base_val = cnt_clr ? '0 : run_peak_val;
  assign peak_base_ch  = cnt_clr ? '0 : run_peak_ch;

  // An ack landing in the commit cycle frees the bank before the publish.
  assign publish = commit_go & (~rd_bus.frame_ready | rd_bus.frame_ack);

  always_ff @(posedge clk_4M or negedge sys_rst) begin
    if (!sys_rst) begin
      ch_cnt             <= '0;
      run_peak_val       <= '0;
      run_peak_ch        <= '0;
      wr_bank            <= 1'b0;
      short_err          <= 1'b0;
      overrun_cnt        <= '0;
      rd_bus.frame_ready <= 1'b0;
      rd_bus.frame_id    <= '0;
      rd_bus.peak_val    <= '0;
      rd_bus.peak_ch     <= '0;
    end else begin
      ch_cnt <= ch_base + ch_cnt_t'(wr_en);
      // Strictly greater keeps the lowest channel on ties.
      if (wr_en && (adc_data > peak_base_val)) begin
        run_peak_val <= adc_data;
        run_peak_ch  <= wr_ch;
      end else begin
        run_peak_val <= peak_base_val;
        run_peak_ch  <= peak_base_ch;
      end
      if (short_set) begin
        short_err <= 1'b1;
      end
      if (publish) begin
        wr_bank            <= ~wr_bank;
        rd_bus.frame_ready <= 1'b1;
        rd_bus.frame_id    <= rd_bus.frame_id + FRAME_ID_W'(1);
        rd_bus.peak_val    <= run_peak_val;
        rd_bus.peak_ch     <= run_peak_ch;
      end else begin
        if (rd_bus.frame_ack) begin
          rd_bus.frame_ready <= 1'b0;
        end
        if (commit_go && (overrun_cnt != '1)) begin
          overrun_cnt <= overrun_cnt + CNT_W'(1);
        end
      end
    end
  end

  sensor_frame_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (CH_W + 1)
  ) u_ram (
    .clk_4M  (clk_4M),
    .sys_rst (sys_rst),
    .wr_en   (wr_en),
    .wr_addr ({wr_bank, wr_ch}),
    .wr_data (adc_data),
    .rd_addr ({~wr_bank, rd_bus.rd_addr}),
    .rd_data (rd_bus.rd_data)
  );

endmodule

// File: tb/tb_sensor_frame_capture.sv
// Bench for sensor_frame_capture: randomized sensor cycles against a
// frame-level reference model (published data array, id, peak, overrun).
module tb_sensor_frame_capture;
  import sensor_pkg::*;

  localparam int CYC = 1042;

  logic              clk_4M = 1'b0;
  logic              sys_rst = 1'b0;
  logic              sen_rst = 1'b1;
  logic              acq_timing = 1'b0;
  logic [DATA_W-1:0] adc_data = '0;
  logic              short_err;
  logic [CNT_W-1:0]  overrun_cnt;

  sensor_frame_capture_if bus();

  sensor_frame_capture dut (
    .clk_4M      (clk_4M),
    .sys_rst     (sys_rst),
    .sen_rst     (sen_rst),
    .acq_timing  (acq_timing),
    .adc_data    (adc_data),
    .short_err   (short_err),
    .overrun_cnt (overrun_cnt),
    .rd_bus      (bus)
  );

  always #5 clk_4M = ~clk_4M;

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // reference model
  logic [DATA_W-1:0] cyc_data [CHANNELS];
  logic [DATA_W-1:0] m_data   [CHANNELS];
  logic [15:0]       m_id, m_ovr;
  logic              m_ready, m_short, m_in_cap;
  int                checks = 0;
  int                errors = 0;

  function automatic logic [DATA_W-1:0] model_peak_val();
    logic [DATA_W-1:0] mx = '0;
    foreach (m_data[i]) if (m_data[i] > mx) mx = m_data[i];
    return mx;
  endfunction

  function automatic logic [CH_W-1:0] model_peak_ch();
    logic [DATA_W-1:0] mx = model_peak_val();
    for (int i = 0; i < CHANNELS; i++) if (m_data[i] == mx) return CH_W'(i);
    return '0;
  endfunction

  task automatic model_reset();
    m_id = '0; m_ovr = '0; m_ready = 1'b0; m_short = 1'b0; m_in_cap = 1'b0;
  endtask

  task automatic fill_data(input int mode);
    for (int i = 0; i < CHANNELS; i++) begin
      case (mode)
        0:       cyc_data[i] = DATA_W'(i);
        1:       cyc_data[i] = 12'hA00 - DATA_W'(i);
        2:       cyc_data[i] = 12'h123;
        default: cyc_data[i] = DATA_W'($urandom_range(0, 4095));
      endcase
    end
  endtask

  task automatic read_word(input logic [CH_W-1:0] a, output logic [DATA_W-1:0] d);
    bus.rd_addr = a;
    @(posedge clk_4M);
    @(negedge clk_4M);
    d = bus.rd_data;
  endtask

  task automatic do_ack();
    @(negedge clk_4M);
    bus.frame_ack = 1'b1;
    @(negedge clk_4M);
    bus.frame_ack = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic strobe(input logic [DATA_W-1:0] d, input bit ack_now);
    acq_timing = 1'b1;
    adc_data   = d;
    @(negedge clk_4M);
    acq_timing = 1'b0;
    adc_data   = DATA_W'($urandom);
    if (ack_now) bus.frame_ack = 1'b1;
    @(negedge clk_4M);
    bus.frame_ack = 1'b0;
    repeat (2) @(negedge clk_4M);
  endtask

  task automatic sen_fall();
    @(negedge clk_4M);
    sen_rst = 1'b1;
    repeat (2) @(negedge clk_4M);
    sen_rst = 1'b0;
    @(negedge clk_4M);
  endtask

  // One sensor cycle of CYC clocks with n strobes; optional ack in the
  // cycle right after the last strobe (the commit cycle).
  task automatic run_cycle(input int n, input bit ack_commit);
    int used = 4;
    if (m_in_cap) m_short = 1'b1;
    sen_fall();
    for (int i = 0; i < n; i++) begin
      strobe(cyc_data[i], ack_commit && (i == CHANNELS - 1));
      used += 4;
    end
    repeat (CYC - used) @(negedge clk_4M);
    if (n == CHANNELS) begin
      m_in_cap = 1'b0;
      if (!m_ready || ack_commit) begin
        m_data  = cyc_data;
        m_id    = m_id + 16'd1;
        m_ready = 1'b1;
      end else if (m_ovr != 16'hFFFF) begin
        m_ovr = m_ovr + 16'd1;
      end
    end else begin
      m_in_cap = 1'b1;
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b0; sen_rst = 1'b1; bus.frame_ack = 1'b0; bus.rd_addr = '0;
    repeat (3) @(negedge clk_4M);
    checks++; if (bus.frame_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %0h expected 0", bus.frame_ready); end
    checks++; if (bus.frame_id !== 16'h0) begin errors++; $display("FAIL rst_id got %0h expected 0", bus.frame_id); end
    checks++; if (bus.peak_val !== 12'h0) begin errors++; $display("FAIL rst_peak_val got %0h expected 0", bus.peak_val); end
    checks++; if (bus.peak_ch !== 8'h0) begin errors++; $display("FAIL rst_peak_ch got %0h expected 0", bus.peak_ch); end
    checks++; if (short_err !== 1'b0) begin errors++; $display("FAIL rst_short got %0h expected 0", short_err); end
    checks++; if (overrun_cnt !== 16'h0) begin errors++; $display("FAIL rst_ovr got %0h expected 0", overrun_cnt); end
    checks++; if (bus.rd_data !== 12'h0) begin errors++; $display("FAIL rst_rd_data got %0h expected 0", bus.rd_data); end
    sys_rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk_4M);
  endtask

  task automatic test_nominal();
    logic [DATA_W-1:0] d;
    logic [CH_W-1:0] a;
    fill_data(0);
    run_cycle(CHANNELS, 1'b0);
    checks++; if (bus.frame_ready !== 1'b1) begin errors++; $display("FAIL nom_ready got %0h expected 1", bus.frame_ready); end
    checks++; if (bus.frame_id !== 16'd1) begin errors++; $display("FAIL nom_id got %0h expected 1", bus.frame_id); end
    checks++; if (bus.peak_val !== 12'h0FF) begin errors++; $display("FAIL nom_peak_val got %0h expected 0ff", bus.peak_val); end
    checks++; if (bus.peak_ch !== 8'd255) begin errors++; $display("FAIL nom_peak_ch got %0h expected ff", bus.peak_ch); end
    read_word(8'h80, d);
    checks++; if (d !== 12'h080) begin errors++; $display("FAIL nom_rd80 got %0h expected 080", d); end
    for (int k = 0; k < 6; k++) begin
      a = CH_W'($urandom);
      read_word(a, d);
      checks++; if (d !== m_data[a]) begin errors++; $display("FAIL nom_rd[%0h] got %0h expected %0h", a, d, m_data[a]); end
    end
  endtask

  task automatic test_overrun();
    logic [DATA_W-1:0] d;
    logic [CH_W-1:0] a;
    for (int c = 0; c < 2; c++) begin
      fill_data(3);
      run_cycle(CHANNELS, 1'b0);
    end
    checks++; if (bus.frame_id !== 16'd1) begin errors++; $display("FAIL ovr_id got %0h expected 1", bus.frame_id); end
    checks++; if (overrun_cnt !== 16'd2) begin errors++; $display("FAIL ovr_cnt got %0h expected 2", overrun_cnt); end
    checks++; if (bus.peak_val !== model_peak_val()) begin errors++; $display("FAIL ovr_peak got %0h expected %0h", bus.peak_val, model_peak_val()); end
    for (int k = 0; k < 8; k++) begin
      a = CH_W'($urandom);
      read_word(a, d);
      checks++; if (d !== DATA_W'(a)) begin errors++; $display("FAIL ovr_rd[%0h] got %0h expected %0h", a, d, a); end
    end
  endtask

  task automatic test_ack_next();
    logic [DATA_W-1:0] d;
    do_ack();
    checks++; if (bus.frame_ready !== 1'b0) begin errors++; $display("FAIL ack_ready got %0h expected 0", bus.frame_ready); end
    fill_data(1);
    run_cycle(CHANNELS, 1'b0);
    checks++; if (bus.frame_id !== m_id) begin errors++; $display("FAIL ack_id got %0h expected %0h", bus.frame_id, m_id); end
    checks++; if (bus.peak_val !== 12'hA00) begin errors++; $display("FAIL ack_peak_val got %0h expected a00", bus.peak_val); end
    checks++; if (bus.peak_ch !== 8'd0) begin errors++; $display("FAIL ack_peak_ch got %0h expected 0", bus.peak_ch); end
    read_word(8'd255, d);
    checks++; if (d !== m_data[255]) begin errors++; $display("FAIL ack_rd255 got %0h expected %0h", d, m_data[255]); end
    do_ack();
    fill_data(2);
    run_cycle(CHANNELS, 1'b0);
    checks++; if (bus.frame_id !== 16'd3) begin errors++; $display("FAIL tie_id got %0h expected 3", bus.frame_id); end
    checks++; if (bus.peak_val !== 12'h123) begin errors++; $display("FAIL tie_peak_val got %0h expected 123", bus.peak_val); end
    checks++; if (bus.peak_ch !== 8'd0) begin errors++; $display("FAIL tie_peak_ch got %0h expected 0", bus.peak_ch); end
  endtask

  task automatic test_short();
    logic [DATA_W-1:0] d;
    logic [CH_W-1:0] a;
    do_ack();
    fill_data(3);
    run_cycle(100, 1'b0);
    checks++; if (bus.frame_ready !== 1'b0) begin errors++; $display("FAIL short_ready got %0h expected 0", bus.frame_ready); end
    checks++; if (bus.frame_id !== m_id) begin errors++; $display("FAIL short_id got %0h expected %0h", bus.frame_id, m_id); end
    fill_data(3);
    run_cycle(CHANNELS, 1'b0);
    checks++; if (short_err !== 1'b1) begin errors++; $display("FAIL short_err got %0h expected 1", short_err); end
    checks++; if (bus.frame_id !== m_id) begin errors++; $display("FAIL short_next_id got %0h expected %0h", bus.frame_id, m_id); end
    checks++; if (bus.peak_ch !== model_peak_ch()) begin errors++; $display("FAIL short_peak_ch got %0h expected %0h", bus.peak_ch, model_peak_ch()); end
    read_word(8'd0, d);
    checks++; if (d !== m_data[0]) begin errors++; $display("FAIL short_rd0 got %0h expected %0h", d, m_data[0]); end
    for (int k = 0; k < 4; k++) begin
      a = CH_W'($urandom);
      read_word(a, d);
      checks++; if (d !== m_data[a]) begin errors++; $display("FAIL short_rd[%0h] got %0h expected %0h", a, d, m_data[a]); end
    end
  endtask

  task automatic test_ack_commit();
    logic [DATA_W-1:0] d;
    logic [CH_W-1:0] a;
    fill_data(3);
    run_cycle(CHANNELS, 1'b1);
    checks++; if (bus.frame_ready !== 1'b1) begin errors++; $display("FAIL ackc_ready got %0h expected 1", bus.frame_ready); end
    checks++; if (bus.frame_id !== m_id) begin errors++; $display("FAIL ackc_id got %0h expected %0h", bus.frame_id, m_id); end
    checks++; if (overrun_cnt !== m_ovr) begin errors++; $display("FAIL ackc_ovr got %0h expected %0h", overrun_cnt, m_ovr); end
    checks++; if (bus.peak_val !== model_peak_val()) begin errors++; $display("FAIL ackc_peak got %0h expected %0h", bus.peak_val, model_peak_val()); end
    for (int k = 0; k < 4; k++) begin
      a = CH_W'($urandom);
      read_word(a, d);
      checks++; if (d !== m_data[a]) begin errors++; $display("FAIL ackc_rd[%0h] got %0h expected %0h", a, d, m_data[a]); end
    end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] d;
    logic [CH_W-1:0] a;
    int n;
    bit ackc;
    for (int c = 0; c < 6; c++) begin
      if ($urandom_range(0, 1) == 1) do_ack();
      n    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 250)) : CHANNELS;
      ackc = ($urandom_range(0, 3) == 0);
      fill_data(3);
      run_cycle(n, ackc);
      checks++; if (bus.frame_ready !== m_ready) begin errors++; $display("FAIL rnd%0d_ready got %0h expected %0h", c, bus.frame_ready, m_ready); end
      checks++; if (bus.frame_id !== m_id) begin errors++; $display("FAIL rnd%0d_id got %0h expected %0h", c, bus.frame_id, m_id); end
      checks++; if (overrun_cnt !== m_ovr) begin errors++; $display("FAIL rnd%0d_ovr got %0h expected %0h", c, overrun_cnt, m_ovr); end
      checks++; if (short_err !== m_short) begin errors++; $display("FAIL rnd%0d_short got %0h expected %0h", c, short_err, m_short); end
      checks++; if (bus.peak_val !== model_peak_val()) begin errors++; $display("FAIL rnd%0d_peak_val got %0h expected %0h", c, bus.peak_val, model_peak_val()); end
      checks++; if (bus.peak_ch !== model_peak_ch()) begin errors++; $display("FAIL rnd%0d_peak_ch got %0h expected %0h", c, bus.peak_ch, model_peak_ch()); end
      for (int k = 0; k < 3; k++) begin
        a = CH_W'($urandom);
        read_word(a, d);
        checks++; if (d !== m_data[a]) begin errors++; $display("FAIL rnd%0d_rd[%0h] got %0h expected %0h", c, a, d, m_data[a]); end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [DATA_W-1:0] d;
    logic [CH_W-1:0] a;
    fill_data(3);
    sen_fall();
    for (int i = 0; i < 50; i++) strobe(cyc_data[i], 1'b0);
    #2 sys_rst = 1'b0;
    #1;
    checks++; if (bus.frame_ready !== 1'b0) begin errors++; $display("FAIL arst_ready got %0h expected 0", bus.frame_ready); end
    checks++; if (bus.frame_id !== 16'h0) begin errors++; $display("FAIL arst_id got %0h expected 0", bus.frame_id); end
    checks++; if (bus.peak_val !== 12'h0) begin errors++; $display("FAIL arst_peak got %0h expected 0", bus.peak_val); end
    checks++; if (short_err !== 1'b0) begin errors++; $display("FAIL arst_short got %0h expected 0", short_err); end
    checks++; if (overrun_cnt !== 16'h0) begin errors++; $display("FAIL arst_ovr got %0h expected 0", overrun_cnt); end
    checks++; if (bus.rd_data !== 12'h0) begin errors++; $display("FAIL arst_rd_data got %0h expected 0", bus.rd_data); end
    @(negedge clk_4M);
    sen_rst = 1'b1;
    @(negedge clk_4M);
    sys_rst = 1'b1;
    model_reset();
    for (int i = 0; i < CHANNELS + 4; i++) strobe(DATA_W'($urandom), 1'b0);
    checks++; if (bus.frame_ready !== 1'b0) begin errors++; $display("FAIL arst_idle_ready got %0h expected 0", bus.frame_ready); end
    checks++; if (bus.frame_id !== 16'h0) begin errors++; $display("FAIL arst_idle_id got %0h expected 0", bus.frame_id); end
    fill_data(3);
    run_cycle(CHANNELS, 1'b0);
    checks++; if (bus.frame_id !== 16'd1) begin errors++; $display("FAIL arst_new_id got %0h expected 1", bus.frame_id); end
    checks++; if (short_err !== 1'b0) begin errors++; $display("FAIL arst_new_short got %0h expected 0", short_err); end
    checks++; if (bus.peak_ch !== model_peak_ch()) begin errors++; $display("FAIL arst_new_peak_ch got %0h expected %0h", bus.peak_ch, model_peak_ch()); end
    for (int k = 0; k < 4; k++) begin
      a = CH_W'($urandom);
      read_word(a, d);
      checks++; if (d !== m_data[a]) begin errors++; $display("FAIL arst_rd[%0h] got %0h expected %0h", a, d, m_data[a]); end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_overrun();
    test_ack_next();
    test_short();
    test_ack_commit();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
